// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, FSM encoding and saturation helper for the polar-to-rect CORDIC
package cordic_pkg;
  localparam int BAU_W = 16;
  localparam int ATAN_N = 12;
  localparam logic [15:0] INV_K = 16'd39797;
  localparam logic [ATAN_N-1:0][BAU_W-1:0] ATAN_TAB = {
    16'd5, 16'd10, 16'd20, 16'd41, 16'd81, 16'd163,
    16'd326, 16'd651, 16'd1297, 16'd2555, 16'd4836, 16'd8192
  };
  typedef enum logic [1:0] {IDLE, ROT, OUT} state_t;
  function automatic logic [8:0] sat9(input logic signed [31:0] v);
    return (v > 255) ? 9'h0ff : (v < -255) ? 9'h101 : v[8:0];
  endfunction
endpackage

// File: rtl/cordic_atan_rom.sv
// cordic_atan_rom: micro-rotation angle lookup in binary angle units, zero past the table end
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [3:0]       i_idx,
  output logic [BAU_W-1:0] o_atan
);
  assign o_atan = (i_idx < 4'(ATAN_N)) ? ATAN_TAB[i_idx] : '0;
endmodule

// File: rtl/polar_to_rect_cordic.sv
// polar_to_rect_cordic: iterative rotation-mode CORDIC turning (mag, angle) into rounded, saturated (x, y)
module polar_to_rect_cordic
  import cordic_pkg::*;
#(
  parameter int ITER = 12,
  parameter int FRAC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] mag,
  input  logic [7:0] angle,
  output logic       busy,
  output logic       done,
  output logic [8:0] x_out,
  output logic [8:0] y_out
);
  localparam int W = 11 + FRAC;
  localparam logic signed [W-1:0] HALF = W'(1 << (FRAC - 1));
  state_t r_state, w_next;
  logic [3:0] r_i;
  logic signed [W-1:0] r_x, r_y;
  logic signed [BAU_W-1:0] r_z;
  logic r_done;
  logic [8:0] r_x_out, r_y_out;
  logic [23:0] w_prod;
  logic signed [W-1:0] w_x0, w_xs, w_ys, w_xn, w_yn, w_xr, w_yr;
  logic signed [BAU_W-1:0] w_z0, w_zn;
  logic [BAU_W-1:0] w_atan;
  logic w_flip, w_pos, w_load;
  cordic_atan_rom u_rom (.i_idx(r_i), .o_atan(w_atan));
  // Angles in the left half-plane are pre-rotated by 180 deg so CORDIC only sees |z| <= 90 deg
  assign w_flip = angle[7] ^ angle[6];
  assign w_prod = {16'b0, mag} * {8'b0, INV_K};
  assign w_x0 = signed'(W'(w_prod >> (16 - FRAC)));
  assign w_z0 = {angle ^ {w_flip, 7'b0}, 8'b0};
  assign w_load = (r_state == IDLE) && start;
  assign w_pos = ~r_z[BAU_W-1];
  assign w_xs = r_x >>> r_i;
  assign w_ys = r_y >>> r_i;
  assign w_xn = w_pos ? r_x - w_ys : r_x + w_ys;
  assign w_yn = w_pos ? r_y + w_xs : r_y - w_xs;
  assign w_zn = w_pos ? r_z - signed'(w_atan) : r_z + signed'(w_atan);
  assign w_xr = (r_x + HALF) >>> FRAC;
  assign w_yr = (r_y + HALF) >>> FRAC;
  always_comb begin
    w_next = w_load ? ROT
           : (r_state == ROT && r_i == 4'(ITER - 1)) ? OUT
           : (r_state == OUT) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i <= '0;
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
      r_done <= 1'b0;
      r_x_out <= '0;
      r_y_out <= '0;
    end else begin
      r_done <= (r_state == OUT);
      if (w_load) begin
        r_i <= '0;
        r_x <= w_flip ? -w_x0 : w_x0;
        r_y <= '0;
        r_z <= w_z0;
      end else if (r_state == ROT) begin
        r_i <= r_i + 4'd1;
        r_x <= w_xn;
        r_y <= w_yn;
        r_z <= w_zn;
      end else if (r_state == OUT) begin
        r_x_out <= sat9(32'(w_xr));
        r_y_out <= sat9(32'(w_yr));
      end
    end
  end
  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign x_out = r_x_out;
  assign y_out = r_y_out;
endmodule
